// File: rtl/vco_freq_ctrl_pkg.sv
// vco_freq_ctrl_pkg: shared state encoding, default parameters and error type for the VCO frequency loop
package vco_freq_ctrl_pkg;
    typedef enum logic [2:0] {IDLE, ALIGN, MEASURE, ADJUST, LOCKED} state_e;
    localparam int unsigned DEF_CNT_W    = 16;
    localparam int unsigned DEF_TOL      = 1;
    localparam int unsigned DEF_LOCK_CNT = 4;
    localparam int unsigned DEF_MAX_STEP = 8;
    typedef logic signed [DEF_CNT_W:0] err_t;
endpackage

// File: rtl/ref_edge_sync.sv
// ref_edge_sync: two-flop synchronizer for the reference clock plus a one-cycle rising-edge pulse
module ref_edge_sync (
    input  logic clk_o,
    input  logic arst_ni,
    input  logic ref_clk_i,
    output logic ref_edge_o
);
    logic [2:0] sync_q;
    always_ff @(posedge clk_o or negedge arst_ni)
        if (!arst_ni) sync_q <= '0;
        else sync_q <= {sync_q[1:0], ref_clk_i};
    assign ref_edge_o = sync_q[1] & ~sync_q[2];
endmodule

// File: rtl/vco_freq_ctrl.sv
// vco_freq_ctrl: digital PLL loop trimming the VCO until clk_o cycles per reference period match the target
module vco_freq_ctrl
    import vco_freq_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W    = DEF_CNT_W,
    parameter int unsigned TOL      = DEF_TOL,
    parameter int unsigned LOCK_CNT = DEF_LOCK_CNT,
    parameter int unsigned MAX_STEP = DEF_MAX_STEP
) (
    input  logic             arst_ni,
    input  logic             clk_o,
    input  logic             ref_clk_i,
    input  logic [CNT_W-1:0] cfg_mult_i,
    input  logic             cfg_valid_i,
    output logic             cfg_ready_o,
    output logic             freq_incr_o,
    output logic             freq_decr_o,
    output logic             stable_cfg_o,
    output logic             locked_o,
    output logic             ref_lost_o,
    output logic [CNT_W-1:0] meas_o
);
    localparam int unsigned LW = $clog2(LOCK_CNT + 1);
    localparam int unsigned SW = $clog2(MAX_STEP + 1);

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, tgt_q;
    logic [LW-1:0]         lock_q;
    logic [SW-1:0]         adj_q, step;
    logic signed [CNT_W:0] err;
    logic [CNT_W:0]        err_abs;
    logic                  ref_edge, accept, measuring, meas_done, out_tol, lock_hit, cnt_max, dn_q;

    ref_edge_sync u_sync (
        .clk_o      (clk_o),
        .arst_ni    (arst_ni),
        .ref_clk_i  (ref_clk_i),
        .ref_edge_o (ref_edge)
    );

    assign cfg_ready_o = 1'b1;
    assign accept      = cfg_valid_i;
    assign err         = $signed({1'b0, cnt_q}) - $signed({1'b0, tgt_q});
    assign err_abs     = err[CNT_W] ? $unsigned(-err) : $unsigned(err);
    assign out_tol     = err_abs > (CNT_W+1)'(TOL);
    assign step        = err_abs > (CNT_W+1)'(MAX_STEP) ? SW'(MAX_STEP) : SW'(err_abs);
    assign lock_hit    = lock_q >= LW'(LOCK_CNT - 1);
    assign cnt_max     = &cnt_q;
    assign measuring   = state_q == MEASURE || state_q == LOCKED;
    assign meas_done   = measuring && ref_edge;
    assign freq_incr_o = state_q == ADJUST && !dn_q;
    assign freq_decr_o = state_q == ADJUST && dn_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ALIGN:           if (ref_edge) state_d = MEASURE;
            MEASURE, LOCKED: if (ref_edge) state_d = out_tol ? ADJUST : lock_hit ? LOCKED : state_q;
                             else if (cnt_max) state_d = ALIGN;
            ADJUST:          if (adj_q == SW'(1)) state_d = ALIGN;
            default:         ;
        endcase
        if (accept) state_d = ALIGN;
    end

    always_ff @(posedge clk_o or negedge arst_ni)
        if (!arst_ni) state_q <= IDLE;
        else state_q <= state_d;

    // Counter restarts at 1 so the edge cycle itself is counted and a P-cycle period reads P
    always_ff @(posedge clk_o or negedge arst_ni) begin
        if (!arst_ni) begin
            cnt_q        <= '0;
            tgt_q        <= '0;
            meas_o       <= '0;
            lock_q       <= '0;
            adj_q        <= '0;
            dn_q         <= 1'b0;
            locked_o     <= 1'b0;
            ref_lost_o   <= 1'b0;
            stable_cfg_o <= 1'b0;
        end else begin
            stable_cfg_o <= !accept && state_q != IDLE;
            if (accept) begin
                tgt_q      <= cfg_mult_i < CNT_W'(2) ? CNT_W'(2) : cfg_mult_i;
                lock_q     <= '0;
                locked_o   <= 1'b0;
                ref_lost_o <= 1'b0;
            end else if (state_q == ALIGN && ref_edge) begin
                cnt_q <= CNT_W'(1);
            end else if (meas_done) begin
                meas_o     <= cnt_q;
                ref_lost_o <= 1'b0;
                cnt_q      <= CNT_W'(1);
                if (out_tol) begin
                    lock_q   <= '0;
                    locked_o <= 1'b0;
                    adj_q    <= step;
                    dn_q     <= !err[CNT_W];
                end else begin
                    lock_q   <= lock_hit ? LW'(LOCK_CNT) : lock_q + 1'b1;
                    locked_o <= locked_o | lock_hit;
                end
            end else if (measuring) begin
                if (cnt_max) begin
                    ref_lost_o <= 1'b1;
                    lock_q     <= '0;
                    locked_o   <= 1'b0;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end else if (state_q == ADJUST) begin
                adj_q <= adj_q - 1'b1;
            end
        end
    end
endmodule
